// File: rtl/mips_cpu_regwrite_arbiter.sv
// Register-file write-port arbiter: two one-entry writeback buffers (ALU port A, load port B)
// drained oldest-first through a registered write stage, plus a pending-write mask for hazard logic.
module mips_cpu_regwrite_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        write,
   output logic [4:0]  wrAddr,
   output logic [31:0] wrData,
   output logic [31:0] pending_mask
);

   logic        full_a, full_b, old_is_a;
   logic [4:0]  addr_a, addr_b;
   logic [31:0] data_a, data_b;

   logic grant_a, grant_b;
   logic load_a, load_b;
   logic next_full_a, next_full_b, next_old_is_a;

   always_comb begin
      grant_a = full_a & (~full_b | old_is_a);
      grant_b = full_b & (~full_a | ~old_is_a);

      a_ready = ~full_a | grant_a;
      b_ready = ~full_b | grant_b;

      // Address-0 results are accepted but never occupy a buffer
      load_a = a_valid & a_ready & (a_addr != 5'd0);
      load_b = b_valid & b_ready & (b_addr != 5'd0);

      next_full_a = load_a | (full_a & ~grant_a);
      next_full_b = load_b | (full_b & ~grant_b);

      // A fresh load is always the younger entry; on a simultaneous load B wins as older
      next_old_is_a = old_is_a;
      if (load_a)
         next_old_is_a = 1'b0;
      else if (load_b)
         next_old_is_a = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_a   <= 1'b0;
         full_b   <= 1'b0;
         old_is_a <= 1'b0;
         addr_a   <= '0;
         addr_b   <= '0;
         data_a   <= '0;
         data_b   <= '0;
         write    <= 1'b0;
         wrAddr   <= '0;
         wrData   <= '0;
      end else begin
         full_a   <= next_full_a;
         full_b   <= next_full_b;
         old_is_a <= next_old_is_a;
         if (load_a) begin
            addr_a <= a_addr;
            data_a <= a_data;
         end
         if (load_b) begin
            addr_b <= b_addr;
            data_b <= b_data;
         end
         write <= grant_a | grant_b;
         if (grant_a) begin
            wrAddr <= addr_a;
            wrData <= data_a;
         end else if (grant_b) begin
            wrAddr <= addr_b;
            wrData <= data_b;
         end
      end
   end

   always_comb begin
      pending_mask = '0;
      if (full_a)
         pending_mask[addr_a] = 1'b1;
      if (full_b)
         pending_mask[addr_b] = 1'b1;
      if (write)
         pending_mask[wrAddr] = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

// File: doc/mips_cpu_regwrite_arbiter.md
# mips_cpu_regwrite_arbiter

Shares the single write port of the 32×32 register file between two writeback requesters: port A (ALU/execute results) and port B (load/memory results). Each port has a one-entry holding buffer with a valid/ready handshake; the arbiter commits the oldest buffered result to the register file through a registered write stage. It also publishes a pending-write mask, which the hazard/stall logic uses to block reads of registers with uncommitted writes.

## Interface
- No parameters. Widths are fixed: 5-bit register address, 32-bit data.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  port A has a result.
- a_addr  input  5  port A destination register.
- a_data  input  32  port A result.
- a_ready  output  1  port A result accepted this edge when a_valid is also high.
- b_valid, b_addr, b_data, b_ready  same as port A, for port B.
- write  output  1  register-file write enable (registered).
- wrAddr  output  5  register-file write address (registered).
- wrData  output  32  register-file write data (registered).
- pending_mask  output  32  bit r set while a write to register r is buffered or in the write stage; bit 0 always 0.

## Operation
- State per port: full_x, addr_x, data_x. Shared state: age bit old_is_a, meaningful only when both buffers are full.
- Handshake: a transfer occurs on a rising edge where valid_x and ready_x are both high.
- ready_x = !full_x | grant_x. It depends only on registered state, so no input-to-ready combinational path exists.
- Address-0 transfers: accepted and discarded. The buffer is not loaded, and no write or pending bit results.
- Grant, computed combinationally from registered state:
  - Only one buffer full: grant that buffer.
  - Both full: grant the older one (old_is_a).
  - Neither full: no grant.
- Age rules:
  - Both buffers become full on the same edge: B is older (a load precedes the ALU op behind it).
  - Otherwise, the buffer filled earlier is older.
  - A buffer that is granted and reloaded on the same edge becomes the younger.
- Write stage, on each edge:
  - Grant present: write<=1, wrAddr<=granted addr, wrData<=granted data, and the granted buffer clears unless it is reloaded on that edge.
  - No grant: write<=0. wrAddr and wrData hold their previous values.
- Same address in both buffers: the oldest-first rule preserves write order, so the younger value ends up in the register.
- pending_mask = decode(addr_a)&full_a | decode(addr_b)&full_b | decode(wrAddr)&write, with bit 0 forced to 0.
- Reset (asynchronous, any time): full_a=full_b=0, old_is_a=0, write=0, wrAddr=0, wrData=0. Hence a_ready=b_ready=1 and pending_mask=0. In-flight results are discarded.

## Timing
- Transfer at edge E0 → buffer full during cycle E0→E1. If that buffer is granted, write=1 during E1→E2 and the register file captures the data at E2. Acceptance to write-enable latency is 1 cycle.
- Throughput: one committed write per cycle total. Each port sustains one result per cycle when it is the only active port.
- Both ports streaming continuously: grants alternate, and each port's ready is high every other cycle.
- The pending bit sets at the acceptance edge and clears at the edge where write deasserts or moves to a different address. It covers the cycle in which the register file is being written.
- Reset deassertion: a transfer is possible on the first rising edge after reset goes high.

## Test plan
- Reset: hold reset low mid-stream with both buffers full → immediately write=0, pending_mask=0, a_ready=b_ready=1. After release, the register file holds no partial writes.
- Single port: A sends (addr 5, 0x1234_5678) at edge E0 → write=1, wrAddr=5, wrData=0x12345678 during E1→E2. pending_mask=0x20 during E0→E2, then 0. Register 5 reads 0x12345678 afterwards.
- Simultaneous: A (3, 0xAAAA_AAAA) and B (3, 0xBBBB_BBBB) accepted on the same edge → B commits first, then A on the next cycle. Register 3 ends at 0xAAAAAAAA. pending bit 3 is held for 3 cycles.
- Age ordering: B loaded at E0 (addr 7), A loaded at E1 (addr 7) while B is still buffered → B written before A. Register 7 ends with A's data.
- Address zero: A sends (0, 0xFFFF_FFFF) → a_ready=1, write stays 0, pending_mask stays 0, register 0 remains 0.
- Back-to-back streaming: A and B each hold valid high with 8 distinct addresses → 16 writes in 16 consecutive cycles, grants alternating, nothing lost or duplicated, and each port's results arrive in issue order.
